// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ResetPC      default first fetch address after reset
//   RstEnable    asserted level of the synchronous reset
//   InstBus      instruction word type
//   IfuStateBus  fetch FSM state type with encodings IfuReq/IfuWait/IfuHold
package ifu_pkg;

  localparam logic [31:0] ResetPC   = 32'h8000_0000;
  localparam logic        RstEnable = 1'b1;

  typedef logic [31:0] InstBus;
  typedef logic [1:0]  IfuStateBus;

  localparam IfuStateBus IfuReq  = 2'd0;
  localparam IfuStateBus IfuWait = 2'd1;
  localparam IfuStateBus IfuHold = 2'd2;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register.
//   clk_i          clock
//   rst_i          synchronous reset, active-high; loads ResetPc
//   redirect_i     load aligned redirect_pc_i (takes priority over incr_i)
//   redirect_pc_i  redirect target, low two bits discarded
//   incr_i         advance by one instruction (+4, modulo 2^32)
//   pc_o           current fetch PC
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] ResetPc = ResetPC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        incr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (incr_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetches one instruction at a time over a
// request/grant/response memory handshake and hands {inst, pc} to idu over
// valid/ready. A redirect moves the fetch PC and squashes any fetch in flight.
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_o_ifu / imem_addr_o_ifu  fetch request and word address
//   imem_gnt_i_ifu                    request accepted
//   imem_rvalid_i_ifu / imem_rdata_i_ifu  response
//   redirect_i_ifu / redirect_pc_i_ifu    fetch redirect
//   valid_o_ifu / ready_i_ifu         handshake toward idu
//   inst_o_ifu / pc_o_ifu             fetched instruction and its PC
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o_ifu,
  output logic [31:0] imem_addr_o_ifu,
  input  logic        imem_gnt_i_ifu,
  input  logic        imem_rvalid_i_ifu,
  input  logic [31:0] imem_rdata_i_ifu,
  input  logic        redirect_i_ifu,
  input  logic [31:0] redirect_pc_i_ifu,
  output logic        valid_o_ifu,
  input  logic        ready_i_ifu,
  output logic [31:0] inst_o_ifu,
  output logic [31:0] pc_o_ifu
);

  IfuStateBus  state_q, state_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  InstBus      inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  // Low for the cycle following reset so every output reads zero there.
  logic        active_q;
  logic        pc_incr;
  logic [31:0] fetch_pc;

  ifu_pc_reg #(
    .ResetPc(RESET_PC)
  ) u_pc_reg (
    .clk_i        (clk),
    .rst_i        (rst),
    .redirect_i   (redirect_i_ifu),
    .redirect_pc_i(redirect_pc_i_ifu),
    .incr_i       (pc_incr),
    .pc_o         (fetch_pc)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc_incr = 1'b0;
    if (active_q) begin
      case (state_q)
        IfuReq: begin
          if (imem_gnt_i_ifu) begin
            state_d = IfuWait;
            // Address already on the bus is stale if a redirect lands now.
            drop_d  = redirect_i_ifu;
          end
        end
        IfuWait: begin
          if (imem_rvalid_i_ifu) begin
            if (redirect_i_ifu || drop_q) begin
              state_d = IfuReq;
              drop_d  = 1'b0;
            end else begin
              state_d = IfuHold;
              inst_d  = imem_rdata_i_ifu;
              pc_d    = fetch_pc;
              valid_d = 1'b1;
              pc_incr = 1'b1;
            end
          end else if (redirect_i_ifu) begin
            drop_d = 1'b1;
          end
        end
        IfuHold: begin
          // A redirect voids any handshake in the same cycle.
          if (redirect_i_ifu || ready_i_ifu) begin
            state_d = IfuReq;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IfuReq;
          drop_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= IfuReq;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      active_q <= 1'b1;
    end
  end

  assign imem_req_o_ifu  = active_q && (state_q == IfuReq);
  assign imem_addr_o_ifu = imem_req_o_ifu ? fetch_pc : 32'h0;
  assign valid_o_ifu     = valid_q;
  assign inst_o_ifu      = inst_q;
  assign pc_o_ifu        = pc_q;

endmodule
